ring_wr_cntrl: RTL

RING_WR_CNTRL -- requirements
Module: ring_wr_cntrl

---
 rtl/ring_wr_cntrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ring_wr_cntrl.sv
// Ring-buffer write controller: fills the buffer, waits for a trigger, writes the
// post-trigger samples, then hands the frozen pointer downstream for readout.
module ring_wr_cntrl #(
    parameter int SIZE    = 12,
    parameter int HOLDOFF = 4
) (
    input  logic            sysclk,
    input  logic            rst,
    input  logic            adc_valid,
    input  logic            trigger,
    input  logic [SIZE-1:0] posttrig_i,
    input  logic            ro_done_n,
    output logic            wr_en,
    output logic [SIZE-1:0] wr_addr,
    output logic [SIZE-1:0] ain,
    output logic            rd_request,
    output logic            armed,
    output logic [7:0]      trig_lost
);

    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    // FILL prime buffer | ARMED await trigger | POST post-trigger writes | READOUT downstream read | HOLD re-arm gap
    typedef enum logic [2:0] {
        ST_FILL,
        ST_ARMED,
        ST_POST,
        ST_READOUT,
        ST_HOLD
    } state_t;

    state_t          state, state_nxt;
    logic [SIZE-1:0] fill_cnt;
    logic [SIZE-1:0] post_cnt;
    logic [SIZE-1:0] wr_addr_nxt;
    logic [1:0]      guard_cnt;
    logic [HW-1:0]   hold_cnt;
    logic            ro_entry;
    logic            hold_entry;
    logic            lost_inc;

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        case (state)
            ST_FILL: begin
                wr_en = adc_valid;
                if (adc_valid && (fill_cnt == '1)) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                wr_en = adc_valid;
                if (trigger) state_nxt = ST_POST;
            end
            ST_POST: begin
                if (post_cnt == '0) begin
                    state_nxt = ST_READOUT;
                end else begin
                    wr_en = adc_valid;
                    if (adc_valid && (post_cnt == SIZE'(1))) state_nxt = ST_READOUT;
                end
            end
            ST_READOUT: begin
                // the first three READOUT cycles are covered by the downstream pipeline guard
                if ((guard_cnt == 2'd0) && !ro_done_n) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_cnt == '0) state_nxt = ST_ARMED;
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    assign wr_addr_nxt = wr_en ? (wr_addr + SIZE'(1)) : wr_addr;
    assign ro_entry    = (state_nxt == ST_READOUT) && (state != ST_READOUT);
    assign hold_entry  = (state_nxt == ST_HOLD) && (state != ST_HOLD);
    assign lost_inc    = trigger && (trig_lost != 8'hFF) &&
                         ((state == ST_POST) || (state == ST_READOUT) || (state == ST_HOLD));
    assign armed       = (state == ST_ARMED);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state      <= ST_FILL;
            wr_addr    <= '0;
            ain        <= '0;
            fill_cnt   <= '0;
            post_cnt   <= '0;
            guard_cnt  <= '0;
            hold_cnt   <= '0;
            rd_request <= 1'b0;
            trig_lost  <= '0;
        end else begin
            state      <= state_nxt;
            wr_addr    <= wr_addr_nxt;
            rd_request <= (state_nxt == ST_READOUT);

            if ((state == ST_FILL) && wr_en) fill_cnt <= fill_cnt + SIZE'(1);

            if ((state == ST_ARMED) && trigger) begin
                post_cnt <= posttrig_i;
            end else if ((state == ST_POST) && wr_en) begin
                post_cnt <= post_cnt - SIZE'(1);
            end

            if (ro_entry) begin
                ain       <= wr_addr_nxt;
                guard_cnt <= 2'd3;
            end else if ((state == ST_READOUT) && (guard_cnt != 2'd0)) begin
                guard_cnt <= guard_cnt - 2'd1;
            end

            if (hold_entry) begin
                hold_cnt <= HW'(HOLDOFF - 1);
            end else if ((state == ST_HOLD) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - HW'(1);
            end

            if (lost_inc) trig_lost <= trig_lost + 8'd1;
        end
    end

endmodule
